// File: rtl/csi2_raw10_unpacker.sv
// csi2_raw10_unpacker: unpacks CSI-2 RAW10 long-packet payload (5 bytes -> 4 pixels)
// Ports: clock_in, reset_in (synchronous, active-high);
//   header_valid_in, data_type_in, word_count_in : decoded packet header strobe and fields
//   payload_valid_in, payload_in                 : payload byte stream, no backpressure
//   frame_valid_out, line_valid_out              : frame / line active
//   pixel_valid_out, pixel_data_out              : 10-bit pixel stream
//   line_count_out                               : lines completed in the current frame
//   error_out                                    : one-cycle protocol error pulse
// Build option: define RAW8_SUPPORT_EN to accept DT 0x2A lines as RAW8 (one pixel per byte).
module csi2_raw10_unpacker #(
  parameter int LINE_COUNT_WIDTH = 16
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
  input  logic                        header_valid_in,
  input  logic [5:0]                  data_type_in,
  input  logic [15:0]                 word_count_in,
  input  logic                        payload_valid_in,
  input  logic [7:0]                  payload_in,
  output logic                        frame_valid_out,
  output logic                        line_valid_out,
  output logic                        pixel_valid_out,
  output logic [9:0]                  pixel_data_out,
  output logic [LINE_COUNT_WIDTH-1:0] line_count_out,
  output logic                        error_out
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FRAME = 2'd1;
  localparam logic [1:0] LINE  = 2'd2;
  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

  logic [1:0]  state, state_n;
  logic [15:0] rem;
  logic [2:0]  grp_cnt;
  logic [7:0]  grp [4];
  logic [29:0] hold;
  logic [1:0]  pend;
  logic        raw8;
  logic        raw8_hdr, fs_hdr, fe_hdr, long_hdr;
  logic        acc, last, done, raw8_pix, line_start, err_n, pv_n, lv_n, fv_n;
  logic [9:0]  pix_n;

`ifdef RAW8_SUPPORT_EN
  assign raw8_hdr = data_type_in == DT_RAW8;
`else
  assign raw8_hdr = 1'b0;
`endif
  assign fs_hdr   = data_type_in == DT_FS;
  assign fe_hdr   = data_type_in == DT_FE;
  assign long_hdr = data_type_in == DT_RAW10 || raw8_hdr;

  // a header in the same cycle as a byte wins; the byte is dropped
  assign acc      = payload_valid_in && !header_valid_in && state == LINE;
  assign last     = acc && rem == 16'd1;
  assign done     = acc && !raw8 && grp_cnt == 3'd4;
  assign raw8_pix = acc && raw8;

  always_comb begin
    state_n    = state;
    err_n      = 1'b0;
    line_start = 1'b0;
    if (header_valid_in) begin
      // a header inside a line aborts it, then is handled as if seen in FRAME
      err_n = payload_valid_in || state == LINE || !(fs_hdr || fe_hdr || long_hdr) ||
              (fs_hdr && state != IDLE) || (long_hdr && state == IDLE);
      if (fs_hdr) state_n = FRAME;
      else if (fe_hdr) state_n = IDLE;
      else if (long_hdr && state != IDLE) begin
        line_start = word_count_in != 16'd0;
        state_n    = line_start ? LINE : FRAME;
      end else if (state == LINE) state_n = FRAME;
    end else if (payload_valid_in) begin
      // stray byte outside a line, or the line ends with a partial RAW10 group
      err_n   = state != LINE || (last && !raw8 && grp_cnt != 3'd4);
      state_n = last ? FRAME : state;
    end
  end

  // group completion and RAW8 bytes never coincide with an undrained holding register
  assign pv_n  = done || raw8_pix || pend != 2'd0;
  assign pix_n = done ? {grp[0], payload_in[1:0]} :
                 raw8_pix ? {payload_in, 2'b00} : hold[9:0];
  // line/frame stay up until pixels already captured have drained
  assign lv_n  = state_n == LINE || (line_valid_out && pv_n);
  assign fv_n  = state_n != IDLE || (frame_valid_out && pv_n);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state           <= IDLE;
      rem             <= '0;
      grp_cnt         <= '0;
      for (int i = 0; i < 4; i++) grp[i] <= '0;
      hold            <= '0;
      pend            <= '0;
      raw8            <= 1'b0;
      frame_valid_out <= 1'b0;
      line_valid_out  <= 1'b0;
      pixel_valid_out <= 1'b0;
      pixel_data_out  <= '0;
      line_count_out  <= '0;
      error_out       <= 1'b0;
    end else begin
      state           <= state_n;
      error_out       <= err_n;
      frame_valid_out <= fv_n;
      line_valid_out  <= lv_n;
      pixel_valid_out <= pv_n;
      if (pv_n) pixel_data_out <= pix_n;
      if (line_start) begin
        rem  <= word_count_in;
        raw8 <= raw8_hdr;
      end else if (acc) rem <= rem - 16'd1;
      if (header_valid_in) grp_cnt <= '0;
      else if (acc) begin
        if (!done) grp[grp_cnt[1:0]] <= payload_in;
        grp_cnt <= (done || last) ? 3'd0 : grp_cnt + 3'd1;
      end
      // pixels 1..3 wait in hold while pixel 0 goes straight to the output
      if (done) begin
        hold <= {grp[3], payload_in[7:6], grp[2], payload_in[5:4], grp[1], payload_in[3:2]};
        pend <= 2'd3;
      end else if (pend != 2'd0) begin
        hold <= {10'd0, hold[29:10]};
        pend <= pend - 2'd1;
      end
      if (header_valid_in && fs_hdr) line_count_out <= '0;
      else if (line_valid_out && !lv_n) line_count_out <= line_count_out + 1'b1;
    end
  end
endmodule

// File: tb/tb_csi2_raw10_unpacker.sv
// tb_csi2_raw10_unpacker: directed table plus multi-cycle sequences for csi2_raw10_unpacker
module tb_csi2_raw10_unpacker;
  logic clk = 1'b0;
  logic rst;
  logic hv, pv;
  logic [5:0] dt;
  logic [15:0] wc;
  logic [7:0] pd;
  logic fv_o, lv_o, pv_o, err_o;
  logic [9:0] px_o;
  logic [15:0] lc_o;
  int total = 0, bad = 0;
  int cyc = 0, pix_cnt = 0, last_pix = 0, errs = 0;
  bit mon = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic h; logic [5:0] d; logic [15:0] w; logic p; logic [7:0] b;
    logic e_pv; logic [9:0] e_px; logic e_lv; logic e_fv; logic e_err; logic [15:0] e_lc;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  csi2_raw10_unpacker #(.LINE_COUNT_WIDTH(16)) dut (
    .clock_in(clk), .reset_in(rst),
    .header_valid_in(hv), .data_type_in(dt), .word_count_in(wc),
    .payload_valid_in(pv), .payload_in(pd),
    .frame_valid_out(fv_o), .line_valid_out(lv_o), .pixel_valid_out(pv_o),
    .pixel_data_out(px_o), .line_count_out(lc_o), .error_out(err_o)
  );

  task automatic row(input bit h, input int d, input int w, input bit p, input int b,
                     input bit epv, input int epx, input bit elv, input bit efv,
                     input bit eer, input int elc);
    vec_t v;
    v.h = h; v.d = 6'(d); v.w = 16'(w); v.p = p; v.b = 8'(b);
    v.e_pv = epv; v.e_px = 10'(epx); v.e_lv = elv; v.e_fv = efv; v.e_err = eer;
    v.e_lc = 16'(elc);
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mon) begin
      if (err_o) errs++;
      if (pv_o) begin
        pix_cnt++;
        last_pix = cyc;
        if (exp_q.size() == 0) chk("px_unexpected", 1, 0);
        else chk("px_stream", int'(px_o), int'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic hdr(input int d, input int w);
    hv = 1'b1; dt = 6'(d); wc = 16'(w); pv = 1'b0;
    tick();
    hv = 1'b0;
  endtask

  task automatic put(input int b);
    pv = 1'b1; pd = 8'(b);
    tick();
    pv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_all0(input string nm);
    chk({nm, "_fv"}, fv_o, 0);
    chk({nm, "_lv"}, lv_o, 0);
    chk({nm, "_pv"}, pv_o, 0);
    chk({nm, "_px"}, px_o, 0);
    chk({nm, "_lc"}, lc_o, 0);
    chk({nm, "_err"}, err_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, npx;
    logic [7:0] b[5];
    //    h  dt    wc p  byte   pv  px     lv fv er lc
    row(1, 'h00, 0, 0, 'h00,  0, 'h000, 0, 1, 0, 0);
    row(1, 'h2B, 5, 0, 'h00,  0, 'h000, 1, 1, 0, 0);
    row(0, 0,    0, 1, 'h10,  0, 'h000, 1, 1, 0, 0);
    row(0, 0,    0, 1, 'h20,  0, 'h000, 1, 1, 0, 0);
    row(0, 0,    0, 1, 'h30,  0, 'h000, 1, 1, 0, 0);
    row(0, 0,    0, 1, 'h40,  0, 'h000, 1, 1, 0, 0);
    row(0, 0,    0, 1, 'hE4,  1, 'h040, 1, 1, 0, 0);
    row(0, 0,    0, 0, 'h00,  1, 'h081, 1, 1, 0, 0);
    row(0, 0,    0, 0, 'h00,  1, 'h0C2, 1, 1, 0, 0);
    row(0, 0,    0, 0, 'h00,  1, 'h103, 1, 1, 0, 0);
    row(0, 0,    0, 0, 'h00,  0, 'h103, 0, 1, 0, 1);
    row(1, 'h2B, 7, 0, 'h00,  0, 'h103, 1, 1, 0, 1);
    row(0, 0,    0, 1, 'h01,  0, 'h103, 1, 1, 0, 1);
    row(0, 0,    0, 1, 'h02,  0, 'h103, 1, 1, 0, 1);
    row(0, 0,    0, 1, 'h03,  0, 'h103, 1, 1, 0, 1);
    row(0, 0,    0, 1, 'h04,  0, 'h103, 1, 1, 0, 1);
    row(0, 0,    0, 1, 'h1B,  1, 'h007, 1, 1, 0, 1);
    row(0, 0,    0, 1, 'hAA,  1, 'h00A, 1, 1, 0, 1);
    row(0, 0,    0, 1, 'hBB,  1, 'h00D, 1, 1, 1, 1);
    row(0, 0,    0, 0, 'h00,  1, 'h010, 1, 1, 0, 1);
    row(0, 0,    0, 0, 'h00,  0, 'h010, 0, 1, 0, 2);
    row(1, 'h2B, 5, 0, 'h00,  0, 'h010, 1, 1, 0, 2);
    row(0, 0,    0, 1, 'h11,  0, 'h010, 1, 1, 0, 2);
    row(0, 0,    0, 1, 'h22,  0, 'h010, 1, 1, 0, 2);
    row(0, 0,    0, 1, 'h33,  0, 'h010, 1, 1, 0, 2);
    row(1, 'h01, 0, 0, 'h00,  0, 'h010, 0, 0, 1, 3);
    row(0, 0,    0, 0, 'h00,  0, 'h010, 0, 0, 0, 3);
    row(0, 0,    0, 1, 'h55,  0, 'h010, 0, 0, 1, 3);
    row(1, 'h2B, 5, 0, 'h00,  0, 'h010, 0, 0, 1, 3);
    row(1, 'h12, 0, 0, 'h00,  0, 'h010, 0, 0, 1, 3);
    row(1, 'h2A, 3, 0, 'h00,  0, 'h010, 0, 0, 1, 3);
    row(1, 'h01, 0, 0, 'h00,  0, 'h010, 0, 0, 0, 3);
    row(1, 'h00, 0, 0, 'h00,  0, 'h010, 0, 1, 0, 0);
    row(1, 'h2B, 0, 0, 'h00,  0, 'h010, 0, 1, 0, 0);
    row(0, 0,    0, 1, 'h66,  0, 'h010, 0, 1, 1, 0);
    row(1, 'h00, 0, 0, 'h00,  0, 'h010, 0, 1, 1, 0);
    row(1, 'h2B, 5, 1, 'h77,  0, 'h010, 1, 1, 1, 0);
    row(1, 'h00, 0, 0, 'h00,  0, 'h010, 0, 1, 1, 0);
    row(1, 'h01, 0, 0, 'h00,  0, 'h010, 0, 0, 0, 0);

    rst = 1'b1; hv = 1'b0; pv = 1'b0; dt = '0; wc = '0; pd = '0;
    idle(2);
    chk_all0("reset");
    rst = 1'b0;

    foreach (tbl[i]) begin
      hv = tbl[i].h; dt = tbl[i].d; wc = tbl[i].w; pv = tbl[i].p; pd = tbl[i].b;
      tick();
      chk($sformatf("tbl%0d_pv", i), pv_o, tbl[i].e_pv);
      chk($sformatf("tbl%0d_px", i), px_o, tbl[i].e_px);
      chk($sformatf("tbl%0d_lv", i), lv_o, tbl[i].e_lv);
      chk($sformatf("tbl%0d_fv", i), fv_o, tbl[i].e_fv);
      chk($sformatf("tbl%0d_err", i), err_o, tbl[i].e_err);
      chk($sformatf("tbl%0d_lc", i), lc_o, tbl[i].e_lc);
    end
    hv = 1'b0; pv = 1'b0;
    idle(2);

    // four 250-byte lines in one frame, FE right behind the last byte
    mon = 1; errs = 0; exp_q.delete();
    hdr('h00, 0);
    for (int l = 0; l < 4; l++) begin
      hdr('h2B, 250);
      pix_cnt = 0;
      for (int g = 0; g < 50; g++) begin
        for (int k = 0; k < 5; k++) b[k] = 8'((g * 5 + k) * 7 + l * 13);
        for (int k = 0; k < 4; k++) exp_q.push_back({b[k], 2'(b[4] >> (2 * k))});
        for (int k = 0; k < 5; k++) put(b[k]);
      end
      if (l < 3) begin
        idle(6);
        chk($sformatf("line%0d_pixels", l), pix_cnt, 200);
        chk($sformatf("line%0d_count", l), lc_o, l + 1);
      end
    end
    hdr('h01, 0);
    n = 0;
    while (fv_o && n < 20) begin
      tick();
      n++;
    end
    chk("fv_fall_timeout", fv_o, 0);
    chk("fv_fall_after_last_px", cyc - last_pix, 1);
    chk("line3_pixels", pix_cnt, 200);
    chk("frame_line_count", lc_o, 4);
    chk("frame_px_left", exp_q.size(), 0);
    chk("frame_errors", errs, 0);
    mon = 0;
    idle(2);

    // reset while pixel 2 of a group is on the output
    hdr('h00, 0);
    hdr('h2B, 5);
    put('h10); put('h20); put('h30); put('h40); put('hE4);
    chk("rst_seq_p0", px_o, 'h040);
    tick();
    tick();
    chk("rst_seq_p2_pv", pv_o, 1);
    chk("rst_seq_p2", px_o, 'h0C2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all0("mid_drain_reset");
    tick();
    chk("post_reset_pv", pv_o, 0);
    hdr('h00, 0);
    chk("post_reset_fv", fv_o, 1);
    hdr('h2B, 5);
    put('h10); put('h20); put('h30); put('h40); put('hE4);
    chk("post_reset_px0", px_o, 'h040);
    idle(3);
    chk("post_reset_px3", px_o, 'h103);
    tick();
    chk("post_reset_lc", lc_o, 1);
    chk("post_reset_lv", lv_o, 0);

    // DT 0x2A in FRAME
    hdr('h2A, 3);
`ifdef RAW8_SUPPORT_EN
    chk("raw8_hdr_err", err_o, 0);
    chk("raw8_lv", lv_o, 1);
    put('hFF);
    chk("raw8_pv0", pv_o, 1);
    chk("raw8_px0", px_o, 'h3FC);
    put('h01);
    chk("raw8_px1", px_o, 'h004);
    put('h80);
    chk("raw8_px2", px_o, 'h200);
    chk("raw8_end_err", err_o, 0);
    tick();
    chk("raw8_done_pv", pv_o, 0);
    chk("raw8_done_lv", lv_o, 0);
    chk("raw8_lc", lc_o, 2);
`else
    chk("raw8_hdr_err", err_o, 1);
    chk("raw8_lv", lv_o, 0);
    npx = 0;
    put('hFF); npx += int'(pv_o);
    put('h01); npx += int'(pv_o);
    put('h80); npx += int'(pv_o);
    tick(); npx += int'(pv_o);
    chk("raw8_no_pixels", npx, 0);
`endif
    hdr('h01, 0);
    tick();
    chk("final_fv", fv_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
